hpdcache_l15_resp_demux_rt: RTL

Routing-table response demultiplexer between the L1.5 memory response channel and N HPDcache requester ports. Each requester records its port number against the transaction ID when it issues a request. When the matching response arrives, the block looks up the port by ID, forwards each beat through an optional per-port output register, and frees the table entry on the last beat. IDs with no table entry are dropped and flagged.

---
 rtl/hpdcache_l15_resp_demux_rt.sv | 139 +++++++++++++
 1 files changed

// File: rtl/hpdcache_l15_resp_demux_rt.sv
// Routing-table response demux: L1.5 response beats are steered to the requester port recorded for their ID.
// HPDCACHE_L15_RESP_DEMUX_OUTREG_EN adds a one-beat output slot per port; undefined gives a 0-latency demux.
module hpdcache_l15_resp_demux_rt #(
    parameter int unsigned N          = 4,
    parameter int unsigned RESP_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4,
    localparam int unsigned RT_DEPTH  = 2**ID_WIDTH,
    localparam int unsigned PW        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           rt_wr_i,
    input  logic [ID_WIDTH-1:0]            rt_wr_id_i,
    input  logic [PW-1:0]                  rt_wr_port_i,
    output logic                           rt_wr_ready_o,
    input  logic                           mem_resp_valid_i,
    output logic                           mem_resp_ready_o,
    input  logic [RESP_WIDTH-1:0]          mem_resp_i,
    input  logic [ID_WIDTH-1:0]            mem_resp_id_i,
    input  logic                           mem_resp_last_i,
    output logic [N-1:0]                   mem_resp_valid_o,
    input  logic [N-1:0]                   mem_resp_ready_i,
    output logic [N-1:0][RESP_WIDTH-1:0]   mem_resp_o,
    output logic                           err_unmapped_o
);

    logic [RT_DEPTH-1:0] rt_valid_q, rt_valid_d;
    logic [PW-1:0]       rt_port_q [RT_DEPTH];
    logic [PW-1:0]       rt_port_d [RT_DEPTH];
    logic                entry_v_s;
    logic [PW-1:0]       tgt_s;
    logic [N-1:0]        sel_s;
    logic                hit_s;
    logic                accept_s;
    logic [N-1:0]        slot_free_s;
    logic                err_unmapped_q, err_unmapped_d;

    // Table lookup; an entry pointing past the last port selects nothing and so counts as a miss
    always_comb begin
        entry_v_s = rt_valid_q[mem_resp_id_i];
        tgt_s     = rt_port_q[mem_resp_id_i];
        sel_s     = '0;
        for (int p = 0; p < N; p++) begin
            sel_s[p] = entry_v_s && (tgt_s == PW'(p));
        end
        hit_s = |sel_s;
    end

    assign mem_resp_ready_o = hit_s ? |(sel_s & slot_free_s) : 1'b1;
    assign accept_s         = mem_resp_valid_i && mem_resp_ready_o;
    assign rt_wr_ready_o    = !rt_valid_q[rt_wr_id_i];

    // Table update: record on write, release on accepted last beat (stale entries are released too)
    always_comb begin
        for (int i = 0; i < RT_DEPTH; i++) begin
            if (rt_wr_i && rt_wr_ready_o && (rt_wr_id_i == ID_WIDTH'(i))) begin
                rt_valid_d[i] = 1'b1;
                rt_port_d[i]  = rt_wr_port_i;
            end else if (accept_s && entry_v_s && mem_resp_last_i && (mem_resp_id_i == ID_WIDTH'(i))) begin
                rt_valid_d[i] = 1'b0;
                rt_port_d[i]  = rt_port_q[i];
            end else begin
                rt_valid_d[i] = rt_valid_q[i];
                rt_port_d[i]  = rt_port_q[i];
            end
        end
    end

    // Unmapped beats are always consumed; flag them one cycle later
    always_comb begin
        err_unmapped_d = mem_resp_valid_i && !hit_s;
    end

    // Routing table and error flag state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rt_valid_q     <= '0;
            err_unmapped_q <= 1'b0;
            for (int i = 0; i < RT_DEPTH; i++) begin
                rt_port_q[i] <= '0;
            end
        end else begin
            rt_valid_q     <= rt_valid_d;
            err_unmapped_q <= err_unmapped_d;
            rt_port_q      <= rt_port_d;
        end
    end

    assign err_unmapped_o = err_unmapped_q;

`ifdef HPDCACHE_L15_RESP_DEMUX_OUTREG_EN
    logic [N-1:0]                 slot_v_q, slot_v_d;
    logic [N-1:0][RESP_WIDTH-1:0] slot_data_q, slot_data_d;

    // An empty slot accepts regardless of its consumer, so idle ports never backpressure
    assign slot_free_s = ~slot_v_q | mem_resp_ready_i;

    // Slot next state: load wins over drain; payload only changes on load
    always_comb begin
        for (int p = 0; p < N; p++) begin
            if (accept_s && sel_s[p]) begin
                slot_v_d[p]    = 1'b1;
                slot_data_d[p] = mem_resp_i;
            end else if (mem_resp_ready_i[p]) begin
                slot_v_d[p]    = 1'b0;
                slot_data_d[p] = slot_data_q[p];
            end else begin
                slot_v_d[p]    = slot_v_q[p];
                slot_data_d[p] = slot_data_q[p];
            end
        end
    end

    // Per-port output slot registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_v_q    <= '0;
            slot_data_q <= '0;
        end else begin
            slot_v_q    <= slot_v_d;
            slot_data_q <= slot_data_d;
        end
    end

    assign mem_resp_valid_o = slot_v_q;
    assign mem_resp_o       = slot_data_q;
`else
    assign slot_free_s = mem_resp_ready_i;

    // Combinational steering; idle ports present zero payload
    always_comb begin
        for (int p = 0; p < N; p++) begin
            mem_resp_valid_o[p] = mem_resp_valid_i && sel_s[p];
            mem_resp_o[p]       = (mem_resp_valid_i && sel_s[p]) ? mem_resp_i : {RESP_WIDTH{1'b0}};
        end
    end
`endif

endmodule
